// File: rtl/serial_rx_deframer.sv
// Serial-to-parallel deframer: assembles LSB-first frames into words and queues them in a small FIFO.
// Optional trailing even-parity check is enabled by defining SNIFFER_PARITY_CHECK_EN.
module serial_rx_deframer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     serial_in_i,
    input  logic                     start_i,
    input  logic                     enable_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     perr_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   fill_o,
    output logic                     overflow_o,
    output logic                     abort_o,
    input  logic                     clear_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

`ifdef SNIFFER_PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

    state_t              state_q, state_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d, shift_in;
    logic                push;
    logic                push_perr;
    logic                abort_evt;
`ifdef SNIFFER_PARITY_CHECK_EN
    logic                par_q, par_d;
`endif

    logic [DATA_W-1:0]   mem [DEPTH];
`ifdef SNIFFER_PARITY_CHECK_EN
    logic                perr_mem [DEPTH];
`endif
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                pop, wr_en, ovf_evt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
`ifdef SNIFFER_PARITY_CHECK_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
`ifdef SNIFFER_PARITY_CHECK_EN
            par_q     <= par_d;
`endif
        end
    end

    // Bits enter at the MSB and shift down, so after DATA_W bits bit n sits at position n.
    assign shift_in = {serial_in_i, shift_q[DATA_W-1:1]};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        push_perr = 1'b0;
        abort_evt = 1'b0;
`ifdef SNIFFER_PARITY_CHECK_EN
        par_d     = par_q;
`endif
        if (enable_i) begin
            if (start_i) begin
                abort_evt = (state_q != IDLE);
                state_d   = DATA;
                bit_cnt_d = BIT_ONE;
                shift_d   = shift_in;
`ifdef SNIFFER_PARITY_CHECK_EN
                par_d     = serial_in_i;
`endif
            end else begin
                case (state_q)
                    IDLE: ;
                    DATA: begin
                        shift_d = shift_in;
`ifdef SNIFFER_PARITY_CHECK_EN
                        par_d   = par_q ^ serial_in_i;
`endif
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
`ifdef SNIFFER_PARITY_CHECK_EN
                            state_d   = PARITY;
`else
                            state_d   = IDLE;
                            push      = 1'b1;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_ONE;
                        end
                    end
`ifdef SNIFFER_PARITY_CHECK_EN
                    PARITY: begin
                        push      = 1'b1;
                        push_perr = par_q ^ serial_in_i;
                        state_d   = IDLE;
                    end
`endif
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // A completion may still be written into a full FIFO when the head is popped in the same cycle.
    assign valid_o = (count_q != '0);
    assign pop     = valid_o && ready_i;
    assign wr_en   = push && ((count_q != FULL) || pop);
    assign ovf_evt = push && (count_q == FULL) && !pop;
    assign fill_o  = count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= shift_d;
`ifdef SNIFFER_PARITY_CHECK_EN
            perr_mem[wr_ptr_q] <= push_perr;
`endif
        end
    end

    // Memory is not reset, so the head is gated to zero whenever the FIFO is empty.
    assign data_o = valid_o ? mem[rd_ptr_q] : '0;
`ifdef SNIFFER_PARITY_CHECK_EN
    assign perr_o = valid_o ? perr_mem[rd_ptr_q] : 1'b0;
`else
    assign perr_o = 1'b0;
    logic unused_perr;
    assign unused_perr = push_perr;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_o <= 1'b0;
            abort_o    <= 1'b0;
        end else begin
            if (ovf_evt)      overflow_o <= 1'b1;
            else if (clear_i) overflow_o <= 1'b0;
            if (abort_evt)    abort_o    <= 1'b1;
            else if (clear_i) abort_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Directed bench for serial_rx_deframer: table of single frames plus FIFO, abort and reset sequences.
// Works with SNIFFER_PARITY_CHECK_EN defined or undefined.
module tb_serial_rx_deframer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
`ifdef SNIFFER_PARITY_CHECK_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              serial_in_i;
    logic              start_i;
    logic              enable_i;
    logic [DATA_W-1:0] data_o;
    logic              perr_o;
    logic              valid_o;
    logic              ready_i;
    logic [$clog2(DEPTH):0] fill_o;
    logic              overflow_o;
    logic              abort_o;
    logic              clear_i;

    int checks   = 0;
    int failures = 0;

    serial_rx_deframer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .serial_in_i (serial_in_i),
        .start_i     (start_i),
        .enable_i    (enable_i),
        .data_o      (data_o),
        .perr_o      (perr_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .fill_o      (fill_o),
        .overflow_o  (overflow_o),
        .abort_o     (abort_o),
        .clear_i     (clear_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] data;
        logic       par_bit;
        logic       toggle;
        logic [7:0] exp_data;
        logic       exp_perr_on;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic st, input logic en);
        serial_in_i = s;
        start_i     = st;
        enable_i    = en;
        tick();
    endtask

    // Disabled cycles carry the inverted bit and start_i=1 so they prove both are ignored.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic toggle, input logic pop_last);
        for (int i = 0; i < DATA_W; i++) begin
            if (toggle) apply_stimulus(~d[i], 1'b1, 1'b0);
            if (pop_last && !PAR_ON && i == DATA_W - 1) ready_i = 1'b1;
            apply_stimulus(d[i], (i == 0), 1'b1);
        end
        if (PAR_ON) begin
            if (pop_last) ready_i = 1'b1;
            apply_stimulus(p, 1'b0, 1'b1);
        end
        serial_in_i = 1'b0;
        start_i     = 1'b0;
        enable_i    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0};
        vecs[4] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0};

        rst_n_i = 1'b0; serial_in_i = 1'b0; start_i = 1'b0; enable_i = 1'b0;
        ready_i = 1'b0; clear_i = 1'b0;
        repeat (3) tick();
        check_output("rst_valid", valid_o, 0);
        check_output("rst_fill", fill_o, 0);
        check_output("rst_data", data_o, 0);
        check_output("rst_perr", perr_o, 0);
        check_output("rst_overflow", overflow_o, 0);
        check_output("rst_abort", abort_o, 0);
        rst_n_i = 1'b1;
        tick();

        ready_i = 1'b1;
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].par_bit, vecs[v].toggle, 1'b0);
            check_output($sformatf("vec%0d_valid", v), valid_o, 1);
            check_output($sformatf("vec%0d_data", v), data_o, vecs[v].exp_data);
            check_output($sformatf("vec%0d_perr", v), perr_o, PAR_ON ? vecs[v].exp_perr_on : 1'b0);
            check_output($sformatf("vec%0d_fill", v), fill_o, 1);
            tick();
            check_output($sformatf("vec%0d_popped", v), valid_o, 0);
        end

        ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b0, 1'b0, 1'b0);
        check_output("full_fill", fill_o, 4);
        check_output("full_no_ovf", overflow_o, 0);
        send_frame(8'h05, 1'b0, 1'b0, 1'b0);
        check_output("ovf_fill", fill_o, 4);
        check_output("ovf_flag", overflow_o, 1);
        ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check_output($sformatf("drain_%0d", k), data_o, k);
            tick();
        end
        check_output("drain_empty", valid_o, 0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_output("ovf_cleared", overflow_o, 0);

        ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b0, 1'b0, 1'b0);
        send_frame(8'h05, 1'b0, 1'b0, 1'b1);
        check_output("pushpop_fill", fill_o, 4);
        check_output("pushpop_no_ovf", overflow_o, 0);
        check_output("pushpop_head", data_o, 2);
        for (int k = 3; k <= 5; k++) begin
            tick();
            check_output($sformatf("pushpop_%0d", k), data_o, k);
        end
        tick();
        check_output("pushpop_empty", valid_o, 0);

        for (int i = 0; i < 4; i++) apply_stimulus(i[0] ? 1'b0 : 1'b1, (i == 0), 1'b1);
        check_output("abort_pre", abort_o, 0);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0);
        check_output("abort_flag", abort_o, 1);
        check_output("abort_valid", valid_o, 1);
        check_output("abort_data", data_o, 8'h7E);
        check_output("abort_fill", fill_o, 1);
        tick();
        check_output("abort_single", valid_o, 0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_output("abort_cleared", abort_o, 0);

        ready_i = 1'b0;
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        check_output("pre_rst_fill", fill_o, 1);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, (i == 0), 1'b1);
        clear_i = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b1);
        clear_i = 1'b0;
        check_output("abort_beats_clear", abort_o, 1);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        enable_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        check_output("midrst_valid", valid_o, 0);
        check_output("midrst_fill", fill_o, 0);
        check_output("midrst_data", data_o, 0);
        check_output("midrst_perr", perr_o, 0);
        check_output("midrst_abort", abort_o, 0);
        check_output("midrst_overflow", overflow_o, 0);
        tick();
        rst_n_i = 1'b1;
        tick();
        ready_i = 1'b1;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        check_output("post_rst_valid", valid_o, 1);
        check_output("post_rst_data", data_o, 8'h11);
        check_output("post_rst_perr", perr_o, 0);
        check_output("post_rst_abort", abort_o, 0);
        check_output("post_rst_fill", fill_o, 1);
        tick();
        check_output("post_rst_empty", valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_rx_deframer.md
# serial_rx_deframer

Downstream consumer of the serial sniffer stage: samples the (possibly corrupted) serial stream qualified by `start_i`/`enable_i` and assembles LSB-first frames into parallel words. Completed words are buffered in a small FIFO and presented on a valid/ready interface, optionally tagged with a parity-error flag. Sticky status flags report dropped words and aborted frames.

## Interface
- `DATA_W`, 8, data bits per frame (≥2)
- `DEPTH`, 4, FIFO entries (power of 2, ≥2)
- `clk_i` input 1 — single clock, all logic on rising edge
- `rst_n_i` input 1 — asynchronous, active-low reset
- `serial_in_i` input 1 — serial data bit, LSB first
- `start_i` input 1 — marks the first data bit of a frame (only meaningful with `enable_i`=1)
- `enable_i` input 1 — bit strobe; a bit is consumed only on cycles with `enable_i`=1
- `data_o` output DATA_W — FIFO head word
- `perr_o` output 1 — parity-error tag of head word
- `valid_o` output 1 — FIFO non-empty
- `ready_i` input 1 — consumer accepts head word when `valid_o`&&`ready_i`
- `fill_o` output $clog2(DEPTH)+1 — current FIFO occupancy
- `overflow_o` output 1 — sticky: a completed word was dropped
- `abort_o` output 1 — sticky: a frame was restarted before completion
- `clear_i` input 1 — synchronous clear of both sticky flags

## Operation
- FSM states: IDLE, DATA, PARITY (PARITY exists only with the macro).
- IDLE: `enable_i`&&`start_i` → capture `serial_in_i` as bit 0, bit counter=1, go DATA. `enable_i` without `start_i` ignored.
- DATA: each `enable_i` cycle shifts in next bit (bit n at position n). After bit DATA_W-1: go PARITY (macro on) or complete frame and go IDLE (macro off).
- PARITY: next `enable_i` bit is the parity bit; even parity over data+parity bit; error = XOR of all DATA_W+1 bits. Complete frame, go IDLE.
- Cycles with `enable_i`=0 hold state and counter in all states (no timeout).
- `start_i`&&`enable_i` in DATA or PARITY: discard partial frame, set `abort_o`, treat bit as bit 0 of a new frame (stay/go DATA, counter=1).
- Frame completion writes {word, perr} into FIFO at `wr_ptr`.
- FIFO: pointers wrap modulo DEPTH; count range 0..DEPTH. Write when completion and (count<DEPTH or pop same cycle). Completion with count==DEPTH and no pop: word dropped, `overflow_o` set, pointers unchanged.
- Pop when `valid_o`&&`ready_i`. Simultaneous push and pop: count unchanged, both pointers advance.
- `data_o`/`perr_o` = entry at `rd_ptr`; undefined content irrelevant when `valid_o`=0 but must be driven (no X from reset: memory not reset, outputs gated to 0 when empty).
- `clear_i`: clears `overflow_o` and `abort_o`; a new overflow/abort event in the same cycle wins (flag stays 1).

## Timing
- Reset (async assert, sync-safe release): FSM IDLE, counter 0, pointers 0, `valid_o`=0, `fill_o`=0, `data_o`=0, `perr_o`=0, `overflow_o`=0, `abort_o`=0. Reset mid-frame discards partial frame.
- Latency: word visible (`valid_o`=1) on the cycle after the edge that samples its last bit (data bit DATA_W-1, or parity bit with macro).
- Minimum frame length: DATA_W enable cycles (DATA_W+1 with macro); back-to-back frames supported with no idle gap.
- `fill_o` and `valid_o` update the cycle after push/pop.
- `ready_i` may be held high; throughput one word per cycle at the output.

## Configuration
- `SNIFFER_PARITY_CHECK_EN` defined: frames carry a trailing even-parity bit, PARITY state present, `perr_o` reflects check.
- Undefined: frames are DATA_W bits only, no PARITY state, `perr_o` tied 0 (FIFO stores no parity bit).

## Test plan
- Single frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), macro on, parity 0, `enable_i` every cycle, `ready_i`=1 → `valid_o` one cycle after parity bit, `data_o`=0xA5, `perr_o`=0.
- Same frame with parity bit 1 → `data_o`=0xA5, `perr_o`=1; with macro off, 8 bits only → `perr_o`=0.
- `enable_i` toggling 1/0 during frame 0x3C → identical result to continuous enable; bits on `enable_i`=0 cycles ignored.
- `ready_i`=0, send 5 frames 0x01..0x05 (DEPTH=4) → `fill_o`=4, `overflow_o`=1; drain reads 0x01..0x04; `clear_i` → `overflow_o`=0.
- FIFO full, 5th frame completes on same cycle as pop → no overflow, drained order 0x02..0x05.
- `start_i` asserted at bit 4 of a frame, then full frame 0x7E → `abort_o`=1, only 0x7E output; assert `rst_n_i`=0 mid-frame → all outputs 0, next frame 0x11 received cleanly.
